riscv_biu_arb: RTL and testbench
================================

RISCV_BIU_ARB -- requirements
Module: riscv_biu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width.
REQ-002 SHALL have parameter PHYS_ADDR_SIZE, default XLEN: address width.
REQ-003 SHALL have parameter DEPTH, default 4: maximum outstanding transfers (power of 2).
REQ-004 SHALL have ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m_stb  in  2  requester strobe; index 0 = instruction side, 1 = data side
- m_stb_ack  out  2  per-requester strobe accept
- m_adri  in  2*PHYS_ADDR_SIZE  per-requester address
- m_size  in  2*3  per-requester transfer size
- m_type  in  2*3  per-requester burst type
- m_lock  in  2  per-requester lock
- m_we  in  2  per-requester write enable
- m_di  in  2*XLEN  per-requester write data
- m_is_cacheable  in  2  per-requester cacheable flag
- m_is_instruction  in  2  per-requester instruction flag
- m_prv  in  2*2  per-requester privilege
- m_do  out  XLEN  read data, broadcast to both requesters
- m_wack, m_rack, m_err  out  2 each  per-requester routed responses
- s_stb  out  1  downstream strobe
- s_stb_ack  in  1  downstream accept
- s_adri, s_size, s_type, s_lock, s_we, s_di, s_is_cacheable, s_is_instruction, s_prv  out  widths as m_*  muxed request fields
- s_do  in  XLEN  downstream read data
- s_wack, s_rack, s_err  in  1 each  downstream responses

Function
REQ-005 Grant SHALL be combinational: one requester asserting m_stb wins; if both assert, the one not granted by the last accepted transfer wins (round-robin). After reset, instruction side wins a tie.
REQ-006 While a requester's last accepted transfer had m_lock=1 and it still asserts m_stb with m_lock=1, grant SHALL stay with it.
REQ-007 s_* request fields SHALL equal the granted requester's fields; with no request they SHALL equal requester 0's fields.
REQ-008 s_stb SHALL be |(m_stb & grant) & ~full; m_stb_ack[i] SHALL be s_stb_ack & grant[i] & ~full.
REQ-009 An accepted transfer (s_stb & s_stb_ack) SHALL push the grant index into an in-order owner FIFO of DEPTH entries and update the round-robin pointer.
REQ-010 Each s_wack, s_rack or s_err pulse SHALL pop the FIFO head and be routed combinationally to m_wack/m_rack/m_err[head]; the other requester's bits SHALL be 0.
REQ-011 A response while FIFO is empty SHALL be dropped (no m_* response, count unchanged).
REQ-012 Simultaneous push and pop SHALL leave the count unchanged; a push into an empty FIFO SHALL NOT be popped in the same cycle.
REQ-013 full (count == DEPTH) SHALL block new strobes; pointers SHALL wrap modulo DEPTH.
REQ-014 m_do SHALL equal s_do with zero latency.

Reset
REQ-015 On rstn low: FIFO count and pointers 0, round-robin pointer = instruction side, lock-hold 0; hence s_stb=0, m_stb_ack=0, m_wack/m_rack/m_err=0.
REQ-016 Reset mid-operation SHALL discard all outstanding ownership; later responses follow REQ-011.

Structure
REQ-017 Requester index constants (IDX_INS=0, IDX_DAT=1) SHALL live in the shared riscv package.
REQ-018 The owner FIFO SHALL be a sub-module riscv_biu_arb_fifo (1-bit wide, DEPTH deep, push/pop/empty/full).

Verification
REQ-019 Data only, m_stb=2'b10, s_stb_ack=1, read; s_rack with s_do=32'hDEADBEEF -> m_rack=2'b10, m_do=32'hDEADBEEF.
REQ-020 Both strobes held for 4 cycles, s_stb_ack=1 -> grants alternate INS,DAT,INS,DAT; FIFO holds 0,1,0,1; four s_rack pulses -> m_rack 01,10,01,10.
REQ-021 Data side issues 4 writes with no s_wack -> fifth m_stb_ack=0 and s_stb=0; one s_wack -> m_wack=2'b10, next strobe accepted.
REQ-022 Data side m_lock=1 for 3 transfers while instruction requests -> data keeps grant for all 3; instruction granted on the 4th cycle.
REQ-023 2 transfers outstanding, rstn pulsed low -> outputs 0; subsequent s_rack -> m_rack=2'b00.
REQ-024 Empty FIFO, accept and s_wack in same cycle -> no m_wack, count=1; next-cycle s_wack -> routed to owner, count=0.

Source files
------------

// File: rtl/riscv_biu_arb_pkg.sv
// Shared definitions for the bus-interface arbiter: requester indices and a small helper.
package riscv_biu_arb_pkg;

    localparam logic IDX_INS = 1'b0;
    localparam logic IDX_DAT = 1'b1;
    localparam int   NREQ    = 2;

    function automatic logic [NREQ-1:0] idx_onehot(input logic idx);
        return (idx == IDX_DAT) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/riscv_biu_arb_fifo.sv
// In-order owner FIFO: remembers which requester owns each outstanding transfer.
module riscv_biu_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic empty_o,
    output logic full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/riscv_biu_arb.sv
// Two-requester (instruction/data) bus arbiter with round-robin, lock hold and in-order response routing.
module riscv_biu_arb
    import riscv_biu_arb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PHYS_ADDR_SIZE = XLEN,
    parameter int DEPTH          = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [1:0]                  m_stb,
    output logic [1:0]                  m_stb_ack,
    input  logic [2*PHYS_ADDR_SIZE-1:0] m_adri,
    input  logic [5:0]                  m_size,
    input  logic [5:0]                  m_type,
    input  logic [1:0]                  m_lock,
    input  logic [1:0]                  m_we,
    input  logic [2*XLEN-1:0]           m_di,
    input  logic [1:0]                  m_is_cacheable,
    input  logic [1:0]                  m_is_instruction,
    input  logic [3:0]                  m_prv,
    output logic [XLEN-1:0]             m_do,
    output logic [1:0]                  m_wack,
    output logic [1:0]                  m_rack,
    output logic [1:0]                  m_err,
    output logic                        s_stb,
    input  logic                        s_stb_ack,
    output logic [PHYS_ADDR_SIZE-1:0]   s_adri,
    output logic [2:0]                  s_size,
    output logic [2:0]                  s_type,
    output logic                        s_lock,
    output logic                        s_we,
    output logic [XLEN-1:0]             s_di,
    output logic                        s_is_cacheable,
    output logic                        s_is_instruction,
    output logic [1:0]                  s_prv,
    input  logic [XLEN-1:0]             s_do,
    input  logic                        s_wack,
    input  logic                        s_rack,
    input  logic                        s_err
);
    localparam int PA = PHYS_ADDR_SIZE;

    logic       rr_q, rr_d;
    logic       lock_q, lock_d;
    logic       lock_idx_q, lock_idx_d;
    logic       gnt_idx, gnt_valid;
    logic [1:0] grant;
    logic       accept, resp, full, empty, head;

    // A locked owner keeps the bus only while it keeps requesting with lock set.
    always_comb begin
        gnt_valid = |m_stb;
        gnt_idx   = IDX_INS;
        if (lock_q && m_stb[lock_idx_q] && m_lock[lock_idx_q]) gnt_idx = lock_idx_q;
        else if (&m_stb)                                        gnt_idx = rr_q;
        else if (m_stb[IDX_DAT])                                gnt_idx = IDX_DAT;
    end

    assign grant  = gnt_valid ? idx_onehot(gnt_idx) : 2'b00;
    assign s_stb  = (|(m_stb & grant)) & ~full;
    assign accept = s_stb & s_stb_ack;
    assign resp   = s_wack | s_rack | s_err;
    assign m_do   = s_do;

    assign s_adri           = gnt_idx ? m_adri[2*PA-1:PA]     : m_adri[PA-1:0];
    assign s_size           = gnt_idx ? m_size[5:3]           : m_size[2:0];
    assign s_type           = gnt_idx ? m_type[5:3]           : m_type[2:0];
    assign s_lock           = m_lock[gnt_idx];
    assign s_we             = m_we[gnt_idx];
    assign s_di             = gnt_idx ? m_di[2*XLEN-1:XLEN]   : m_di[XLEN-1:0];
    assign s_is_cacheable   = m_is_cacheable[gnt_idx];
    assign s_is_instruction = m_is_instruction[gnt_idx];
    assign s_prv            = gnt_idx ? m_prv[3:2]            : m_prv[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_route
            assign m_stb_ack[gi] = s_stb_ack & grant[gi] & ~full;
            assign m_wack[gi]    = s_wack & ~empty & (head == 1'(gi));
            assign m_rack[gi]    = s_rack & ~empty & (head == 1'(gi));
            assign m_err[gi]     = s_err  & ~empty & (head == 1'(gi));
        end
    endgenerate

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            rr_d       = ~gnt_idx;
            lock_d     = m_lock[gnt_idx];
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q       <= IDX_INS;
            lock_q     <= 1'b0;
            lock_idx_q <= IDX_INS;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Pop uses the registered empty flag, so a same-cycle push is never popped.
    riscv_biu_arb_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (accept),
        .din_i   (gnt_idx),
        .pop_i   (resp),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

endmodule

// File: tb/tb_riscv_biu_arb.sv
// Random plus directed bench for riscv_biu_arb against a queue-based ownership model.
module tb_riscv_biu_arb;
    localparam int XLEN  = 32;
    localparam int PA    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [1:0]      m_stb, m_stb_ack, m_lock, m_we, m_is_cacheable, m_is_instruction;
    logic [2*PA-1:0] m_adri;
    logic [5:0]      m_size, m_type;
    logic [63:0]     m_di;
    logic [3:0]      m_prv;
    logic [31:0]     m_do;
    logic [1:0]      m_wack, m_rack, m_err;
    logic            s_stb, s_stb_ack, s_lock, s_we, s_is_cacheable, s_is_instruction;
    logic [31:0]     s_adri, s_di, s_do;
    logic [2:0]      s_size, s_type;
    logic [1:0]      s_prv;
    logic            s_wack, s_rack, s_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner queue, round-robin winner on tie, lock holder.
    int mq[$];
    int rr      = 0;
    bit lk      = 0;
    int lk_idx  = 0;

    always #5 clk = ~clk;

    riscv_biu_arb #(.XLEN(XLEN), .PHYS_ADDR_SIZE(PA), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .m_stb(m_stb), .m_stb_ack(m_stb_ack), .m_adri(m_adri), .m_size(m_size),
        .m_type(m_type), .m_lock(m_lock), .m_we(m_we), .m_di(m_di),
        .m_is_cacheable(m_is_cacheable), .m_is_instruction(m_is_instruction),
        .m_prv(m_prv), .m_do(m_do), .m_wack(m_wack), .m_rack(m_rack), .m_err(m_err),
        .s_stb(s_stb), .s_stb_ack(s_stb_ack), .s_adri(s_adri), .s_size(s_size),
        .s_type(s_type), .s_lock(s_lock), .s_we(s_we), .s_di(s_di),
        .s_is_cacheable(s_is_cacheable), .s_is_instruction(s_is_instruction),
        .s_prv(s_prv), .s_do(s_do), .s_wack(s_wack), .s_rack(s_rack), .s_err(s_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Model compare: evaluated mid-cycle with inputs stable, then advanced for the coming edge.
    always @(negedge clk) begin
        int         g;
        int         h;
        bit         full, exp_stb;
        logic [1:0] oh, ea, ew, er, ee;
        if (!rstn) begin
            mq.delete();
            rr = 0; lk = 0; lk_idx = 0;
        end
        full = (mq.size() == DEPTH);
        if (lk && m_stb[lk_idx] && m_lock[lk_idx]) g = lk_idx;
        else if (m_stb == 2'b11)                   g = rr;
        else if (m_stb[1])                         g = 1;
        else                                       g = 0;
        exp_stb = (m_stb != 2'b00) && !full;
        oh = (g == 1) ? 2'b10 : 2'b01;
        ea = (exp_stb && s_stb_ack) ? oh : 2'b00;
        h  = (mq.size() > 0) ? mq[0] : -1;
        ew = (h >= 0 && s_wack) ? ((h == 1) ? 2'b10 : 2'b01) : 2'b00;
        er = (h >= 0 && s_rack) ? ((h == 1) ? 2'b10 : 2'b01) : 2'b00;
        ee = (h >= 0 && s_err)  ? ((h == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("s_stb", s_stb, exp_stb);
        chk("m_stb_ack", m_stb_ack, ea);
        chk("s_adri", s_adri, (g == 1) ? m_adri[63:32] : m_adri[31:0]);
        chk("s_size", s_size, (g == 1) ? m_size[5:3] : m_size[2:0]);
        chk("s_type", s_type, (g == 1) ? m_type[5:3] : m_type[2:0]);
        chk("s_lock", s_lock, m_lock[g]);
        chk("s_we", s_we, m_we[g]);
        chk("s_di", s_di, (g == 1) ? m_di[63:32] : m_di[31:0]);
        chk("s_is_cacheable", s_is_cacheable, m_is_cacheable[g]);
        chk("s_is_instruction", s_is_instruction, m_is_instruction[g]);
        chk("s_prv", s_prv, (g == 1) ? m_prv[3:2] : m_prv[1:0]);
        chk("m_wack", m_wack, ew);
        chk("m_rack", m_rack, er);
        chk("m_err", m_err, ee);
        chk("m_do", m_do, s_do);
        if (rstn) begin
            if ((s_wack || s_rack || s_err) && mq.size() > 0) void'(mq.pop_front());
            if (exp_stb && s_stb_ack) begin
                mq.push_back(g);
                rr = 1 - g;
                lk = m_lock[g];
                lk_idx = g;
                $display("xfer owner=%0d adr=%h we=%0b lock=%0b outstanding=%0d",
                         g, s_adri, s_we, s_lock, mq.size());
            end
        end
    end

    task automatic idle();
        m_stb = 0; m_lock = 0; m_we = 0; m_is_cacheable = 0; m_is_instruction = 2'b01;
        m_adri = 64'h0000_2000_0000_1000; m_size = 6'o22; m_type = 0;
        m_di = 64'hDDDD_0001_1111_0000; m_prv = 4'b1111;
        s_stb_ack = 0; s_do = 0; s_wack = 0; s_rack = 0; s_err = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic randomize_inputs();
        m_stb            = 2'($urandom_range(0, 3));
        m_lock           = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        m_we             = 2'($urandom);
        m_is_cacheable   = 2'($urandom);
        m_is_instruction = 2'($urandom);
        m_adri           = {$urandom, $urandom};
        m_size           = 6'($urandom);
        m_type           = 6'($urandom);
        m_di             = {$urandom, $urandom};
        m_prv            = 4'($urandom);
        s_stb_ack        = ($urandom_range(0, 3) != 0);
        s_do             = $urandom;
        s_wack           = 0; s_rack = 0; s_err = 0;
        case ($urandom_range(0, 5))
            0: s_wack = 1;
            1: s_rack = 1;
            2: s_err  = 1;
            3: begin s_rack = 1; s_wack = 1; end
            default: ;
        endcase
    endtask

    initial begin
        idle();
        rstn = 0;
        #1;
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_m_stb_ack", m_stb_ack, 2'b00);
        repeat (3) @(posedge clk);
        #2 rstn = 1;

        // Single data-side read
        m_stb = 2'b10; s_stb_ack = 1;
        #1 chk("d19_ack", m_stb_ack, 2'b10);
        cyc(); idle(); s_rack = 1; s_do = 32'hDEADBEEF;
        #1 chk("d19_rack", m_rack, 2'b10);
        chk("d19_do", m_do, 32'hDEADBEEF);
        cyc(); idle();

        // Round-robin on a held tie, responses in order
        for (int i = 0; i < 4; i++) begin
            m_stb = 2'b11; s_stb_ack = 1;
            #1 chk("d20_gnt", m_stb_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            s_rack = 1;
            #1 chk("d20_rack", m_rack, (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        idle();

        // Full FIFO blocks until a response frees a slot
        for (int i = 0; i < 4; i++) begin
            m_stb = 2'b10; m_we = 2'b10; s_stb_ack = 1;
            #1 chk("d21_ack", m_stb_ack, 2'b10);
            cyc();
        end
        #1 chk("d21_full_ack", m_stb_ack, 2'b00);
        chk("d21_full_stb", s_stb, 1'b0);
        s_wack = 1;
        #1 chk("d21_wack", m_wack, 2'b10);
        cyc(); s_wack = 0;
        #1 chk("d21_after", m_stb_ack, 2'b10);
        cyc(); idle(); s_wack = 1;
        repeat (4) cyc();
        idle();

        // Lock hold: data keeps the bus while locked, instruction wins afterwards
        m_stb = 2'b01; s_stb_ack = 1;
        #1 chk("d22_pre", m_stb_ack, 2'b01);
        cyc(); idle(); s_rack = 1;
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            m_stb = 2'b11; m_lock = 2'b10; s_stb_ack = 1;
            #1 chk("d22_lock", m_stb_ack, 2'b10);
            cyc();
        end
        m_stb = 2'b11; m_lock = 2'b00; s_stb_ack = 1;
        #1 chk("d22_release", m_stb_ack, 2'b01);
        cyc(); idle(); s_rack = 1;
        repeat (4) cyc();
        idle();

        // Reset with transfers outstanding discards ownership
        m_stb = 2'b01; s_stb_ack = 1;
        cyc(); cyc();
        idle(); rstn = 0; s_rack = 1;
        #1 chk("d23_rst_rack", m_rack, 2'b00);
        chk("d23_rst_stb", s_stb, 1'b0);
        cyc(); rstn = 1; s_rack = 1;
        #1 chk("d23_rack", m_rack, 2'b00);
        cyc(); idle();

        // Push into empty with a same-cycle response
        m_stb = 2'b01; s_stb_ack = 1; s_wack = 1;
        #1 chk("d24_nowack", m_wack, 2'b00);
        chk("d24_ack", m_stb_ack, 2'b01);
        cyc(); idle(); s_wack = 1;
        #1 chk("d24_wack", m_wack, 2'b01);
        cyc(); idle(); s_wack = 1;
        #1 chk("d24_empty", m_wack, 2'b00);
        cyc(); idle();

        // Randomized phase with occasional reset pulses
        for (int i = 0; i < 800; i++) begin
            randomize_inputs();
            rstn = ($urandom_range(0, 199) != 0);
            cyc();
        end
        idle(); rstn = 1;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
